// File: rtl/sd_block_responder.sv
// ---------------------------------------------------------------------------
// sd_block_responder
//
// Host-side responder for a floppy controller's SD block interface. Sector
// requests (sd_rd / sd_wr with sd_lba) are serviced against a byte-wide image
// memory. Each request moves one 512-byte block:
//   - Read:  each byte is fetched from image memory and presented on
//            sd_buff_addr / sd_buff_dout with a one-cycle sd_buff_wr strobe.
//   - Write: sd_buff_addr is presented, sd_buff_din is captured one cycle
//            later, and the byte is written to image memory.
// Blocks that lie outside the mounted image still complete the full
// handshake. Reads of such blocks return 0x00, and writes to them are dropped.
// A mount strobe latches the image size and emits a one-cycle img_mounted
// pulse.
//
// Parameters
//   MEM_AW      image memory byte-address width (image <= 2^MEM_AW bytes)
//   MEM_TIMEOUT cycles to wait for mem_ready before a byte is abandoned
//
// Ports
//   clk_sys, reset_n            clock, synchronous active-low reset
//   mount_strobe, mount_size    new image notification and its byte size
//   img_mounted, img_size       one-cycle mount pulse, registered size
//   sd_lba, sd_rd, sd_wr        block request (level-sensitive)
//   sd_ack                      high while a block transfer is in progress
//   sd_buff_addr/dout/din/wr    byte stream to/from the controller
//   mem_addr/rd/wr/wdata        image memory request (held until mem_ready)
//   mem_rdata, mem_ready        image memory response (one-cycle ready)
//
// Optional feature (macro SDRESP_WP_EN): adds input wp and output wr_blocked.
// When wp is high at request acceptance, a write block runs its full
// handshake but never asserts mem_wr. In that case wr_blocked is set and
// stays set until reset or the next mount_strobe.
// ---------------------------------------------------------------------------
module sd_block_responder #(
   parameter int MEM_AW      = 20,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              mount_strobe,
   input  logic [19:0]       mount_size,
   output logic              img_mounted,
   output logic [19:0]       img_size,
   input  logic [31:0]       sd_lba,
   input  logic              sd_rd,
   input  logic              sd_wr,
   output logic              sd_ack,
   output logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_dout,
   input  logic [7:0]        sd_buff_din,
   output logic              sd_buff_wr,
`ifdef SDRESP_WP_EN
   input  logic              wp,
   output logic              wr_blocked,
`endif
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_MEM, S_RD_PUT, S_WR_ADDR, S_WR_CAP, S_WR_MEM, S_DONE
   } state_t;

   state_t              r_state;
   logic                r_img_mounted;
   logic [19:0]         r_img_size;
   logic [MEM_AW-10:0]  r_lba;        // only the bits that can address the image
   logic                r_in_range;
   logic                r_ack;
   logic [8:0]          r_idx;        // doubles as sd_buff_addr
   logic [7:0]          r_dout;
   logic                r_buff_wr;
   logic [MEM_AW-1:0]   r_mem_addr;
   logic                r_mem_rd;
   logic                r_mem_wr;
   logic [7:0]          r_mem_wdata;
   logic [TW-1:0]       r_timer;

   logic                w_lba_fits;
   logic                w_in_range;
   logic [MEM_AW-1:0]   w_byte_addr;
   logic                w_last;
   logic                w_timeout;
   logic                w_wr_skip;

   // The range check runs on the full 32-bit LBA in a 42-bit sum, so a huge
   // LBA can never alias into the image through truncation or overflow.
   assign w_lba_fits  = (sd_lba >> (MEM_AW - 9)) == 32'd0;
   assign w_in_range  = w_lba_fits &&
                        (({1'b0, sd_lba, 9'd0} + 42'd512) <= {22'd0, r_img_size});
   // lba*512 has nine zero LSBs, so adding idx is a concatenation.
   assign w_byte_addr = {r_lba, r_idx};
   assign w_last      = (r_idx == 9'd511);
   assign w_timeout   = (r_timer == TW'(MEM_TIMEOUT - 1));

`ifdef SDRESP_WP_EN
   logic r_wp;
   logic r_wr_blocked;
   assign w_wr_skip  = !r_in_range || r_wp;
   assign wr_blocked = r_wr_blocked;
`else
   assign w_wr_skip  = !r_in_range;
`endif

   // NOTE: every register below is assigned with <= so that all of them
   // update together from the values sampled at this edge. A blocking = here
   // would let later statements see half-updated state.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_img_mounted <= 1'b0;
         r_img_size    <= '0;
         r_lba         <= '0;
         r_in_range    <= 1'b0;
         r_ack         <= 1'b0;
         r_idx         <= '0;
         r_dout        <= '0;
         r_buff_wr     <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_rd      <= 1'b0;
         r_mem_wr      <= 1'b0;
         r_mem_wdata   <= '0;
         r_timer       <= '0;
`ifdef SDRESP_WP_EN
         r_wp          <= 1'b0;
         r_wr_blocked  <= 1'b0;
`endif
      end else begin
         r_img_mounted <= mount_strobe;
         if (mount_strobe) r_img_size <= mount_size;
`ifdef SDRESP_WP_EN
         if (mount_strobe) r_wr_blocked <= 1'b0;
`endif
         r_buff_wr <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (sd_rd || sd_wr) begin
                  r_lba      <= sd_lba[MEM_AW-10:0];
                  r_in_range <= w_in_range;   // frozen for the whole block
                  r_ack      <= 1'b1;
                  r_idx      <= '0;
                  r_state    <= sd_rd ? S_RD_MEM : S_WR_ADDR;
`ifdef SDRESP_WP_EN
                  r_wp       <= wp;
                  if (!sd_rd && wp) r_wr_blocked <= 1'b1;
`endif
               end
            end

            S_RD_MEM: begin
               if (r_in_range && !r_mem_rd) begin
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= w_byte_addr;
                  r_timer    <= '0;
               end else if (!r_in_range || mem_ready || w_timeout) begin
                  // Out-of-range and abandoned bytes both read as 0x00.
                  r_dout    <= (r_in_range && mem_ready) ? mem_rdata : 8'h00;
                  r_mem_rd  <= 1'b0;
                  r_buff_wr <= 1'b1;
                  r_state   <= S_RD_PUT;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            S_RD_PUT: begin
               if (w_last) begin
                  r_ack   <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 9'd1;
                  r_state <= S_RD_MEM;
               end
            end

            // sd_buff_addr (= idx) is on the bus during this cycle, and the
            // controller returns the data byte during the next one.
            S_WR_ADDR: r_state <= S_WR_CAP;

            S_WR_CAP: begin
               r_mem_wdata <= sd_buff_din;
               r_state     <= S_WR_MEM;
            end

            S_WR_MEM: begin
               if (!w_wr_skip && !r_mem_wr) begin
                  r_mem_wr   <= 1'b1;
                  r_mem_addr <= w_byte_addr;
                  r_timer    <= '0;
               end else if (w_wr_skip || mem_ready || w_timeout) begin
                  r_mem_wr <= 1'b0;
                  if (w_last) begin
                     r_ack   <= 1'b0;
                     r_state <= S_DONE;
                  end else begin
                     r_idx   <= r_idx + 9'd1;
                     r_state <= S_WR_ADDR;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            // A request still held high must be released before the next
            // one is accepted.
            S_DONE: if (!sd_rd && !sd_wr) r_state <= S_IDLE;

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign img_mounted  = r_img_mounted;
   assign img_size     = r_img_size;
   assign sd_ack       = r_ack;
   assign sd_buff_addr = r_idx;
   assign sd_buff_dout = r_dout;
   assign sd_buff_wr   = r_buff_wr;
   assign mem_addr     = r_mem_addr;
   assign mem_rd       = r_mem_rd;
   assign mem_wr       = r_mem_wr;
   assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_sd_block_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_block_responder
//
// Scoreboard bench for sd_block_responder.
//
// Stimulus tasks push the expected byte strobes and memory operations into
// queues. The expected values come from an array model of the image and
// block arithmetic (lba*512 + i, in range iff lba*512+512 <= size).
// Independent monitors pop and compare whenever the DUT strobes
// sd_buff_wr or a memory access completes. All driving and sampling happens
// on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_block_responder;

   localparam int MEM_AW      = 20;
   localparam int MEM_TIMEOUT = 255;
   localparam int MEM_BYTES   = 1 << MEM_AW;
   localparam int XFER_BUDGET = 20000;

   typedef struct packed {
      logic [8:0] addr;
      logic [7:0] data;
   } strobe_t;

   typedef struct packed {
      logic              is_wr;
      logic [MEM_AW-1:0] addr;
      logic [7:0]        data;
   } memop_t;

   logic              clk_sys;
   logic              reset_n;
   logic              mount_strobe;
   logic [19:0]       mount_size;
   logic              img_mounted;
   logic [19:0]       img_size;
   logic [31:0]       sd_lba;
   logic              sd_rd;
   logic              sd_wr;
   logic              sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic [7:0]        sd_buff_din;
   logic              sd_buff_wr;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_ready;
`ifdef SDRESP_WP_EN
   logic              wp;
   logic              wr_blocked;
`endif

   sd_block_responder #(.MEM_AW(MEM_AW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .mount_strobe (mount_strobe),
      .mount_size   (mount_size),
      .img_mounted  (img_mounted),
      .img_size     (img_size),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_addr (sd_buff_addr),
      .sd_buff_dout (sd_buff_dout),
      .sd_buff_din  (sd_buff_din),
      .sd_buff_wr   (sd_buff_wr),
`ifdef SDRESP_WP_EN
      .wp           (wp),
      .wr_blocked   (wr_blocked),
`endif
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // ---------------- model state and scoreboard ----------------
   logic [7:0] mem_img [MEM_BYTES];
   strobe_t    exp_strobe[$];
   memop_t     exp_mem[$];
   logic [19:0] model_img_size;

   int n_checks, n_pass;
   int n_strobes, n_rd_done, n_wr_done, n_rd_cycles, n_wr_cycles;
   int lat;                 // memory latency in cycles (ready on the lat+1-th cycle)
   int stuck_target;        // memory ignores accesses until n_stuck_done reaches this
   int n_stuck_done;
   int stuck_len, last_stuck_len, wait_cnt;
   bit stuck_pending;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Controller side: returns ~addr one cycle after the address is shown.
   always @(negedge clk_sys) sd_buff_din = ~sd_buff_addr[7:0];

   // Read-strobe monitor.
   always @(negedge clk_sys) begin
      if (reset_n && sd_buff_wr) begin
         strobe_t e;
         n_strobes++;
         check("strobe_expected", 64'(exp_strobe.size() != 0), 64'd1);
         if (exp_strobe.size() != 0) begin
            e = exp_strobe.pop_front();
            check("sd_buff_addr", 64'(sd_buff_addr), 64'(e.addr));
            check("sd_buff_dout", 64'(sd_buff_dout), 64'(e.data));
         end
         check("ack_during_strobe", 64'(sd_ack), 64'd1);
      end
   end

   // Image memory model and memory-operation monitor.
   always @(negedge clk_sys) begin
      mem_ready = 1'b0;
      if (mem_rd) n_rd_cycles++;
      if (mem_wr) n_wr_cycles++;
      if (!reset_n) begin
         wait_cnt = 0;
      end else if (mem_rd || mem_wr) begin
         if (n_stuck_done < stuck_target) begin
            stuck_pending = 1'b1;
            stuck_len++;
         end else if (wait_cnt >= lat) begin
            memop_t e;
            wait_cnt  = 0;
            mem_ready = 1'b1;
            check("mem_op_expected", 64'(exp_mem.size() != 0), 64'd1);
            if (exp_mem.size() != 0) begin
               e = exp_mem.pop_front();
               check("mem_op_kind", 64'(mem_wr), 64'(e.is_wr));
               check("mem_addr", 64'(mem_addr), 64'(e.addr));
               if (mem_wr) check("mem_wdata", 64'(mem_wdata), 64'(e.data));
            end
            if (mem_wr) begin
               mem_img[mem_addr] = mem_wdata;
               n_wr_done++;
            end else begin
               mem_rdata = mem_img[mem_addr];
               n_rd_done++;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
         if (stuck_pending) begin
            stuck_pending  = 1'b0;
            last_stuck_len = stuck_len;
            stuck_len      = 0;
            n_stuck_done++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic bit model_in_range(input logic [31:0] lba);
      longint base = longint'(lba) * 512;
      return (lba < (32'd1 << (MEM_AW - 9))) && (base + 512 <= longint'(model_img_size));
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, " img_mounted"},  64'(img_mounted),  64'd0);
      check({tag, " img_size"},     64'(img_size),     64'd0);
      check({tag, " sd_ack"},       64'(sd_ack),       64'd0);
      check({tag, " sd_buff_addr"}, 64'(sd_buff_addr), 64'd0);
      check({tag, " sd_buff_dout"}, 64'(sd_buff_dout), 64'd0);
      check({tag, " sd_buff_wr"},   64'(sd_buff_wr),   64'd0);
      check({tag, " mem_addr"},     64'(mem_addr),     64'd0);
      check({tag, " mem_rd"},       64'(mem_rd),       64'd0);
      check({tag, " mem_wr"},       64'(mem_wr),       64'd0);
      check({tag, " mem_wdata"},    64'(mem_wdata),    64'd0);
   endtask

   task automatic do_mount(input logic [19:0] sz);
      @(negedge clk_sys);
      mount_strobe = 1'b1;
      mount_size   = sz;
      @(negedge clk_sys);
      mount_strobe = 1'b0;
      model_img_size = sz;
      check("img_mounted_pulse", 64'(img_mounted), 64'd1);
      check("img_size", 64'(img_size), 64'(sz));
      @(negedge clk_sys);
      check("img_mounted_one_cycle", 64'(img_mounted), 64'd0);
   endtask

   // Queue the expectations for one block. A read with `stuck` > 0 loses
   // its first `stuck` bytes to the memory timeout, and they read as 0x00.
   task automatic push_expect(input bit is_read, input logic [31:0] lba,
                              input bit blocked, input int stuck);
      bit in_rng = model_in_range(lba);
      int base   = int'(lba) * 512;
      for (int i = 0; i < 512; i++) begin
         if (is_read) begin
            logic [7:0] d;
            d = (in_rng && i >= stuck) ? mem_img[base + i] : 8'h00;
            exp_strobe.push_back({9'(i), d});
            if (in_rng && i >= stuck) exp_mem.push_back({1'b0, MEM_AW'(base + i), 8'h00});
         end else if (in_rng && !blocked) begin
            exp_mem.push_back({1'b1, MEM_AW'(base + i), ~8'(i)});
         end
      end
   endtask

   task automatic xfer(input string tag, input bit rd, input bit wr, input logic [31:0] lba,
                       input bit wp_in, input int stuck, input int hold);
      bit is_read = rd;
      bit in_rng  = model_in_range(lba);
      int s0 = n_strobes, rdd0 = n_rd_done, wrd0 = n_wr_done;
      int rdc0 = n_rd_cycles, wrc0 = n_wr_cycles;
      int cyc = 0;
      push_expect(is_read, lba, wp_in, stuck);
      @(negedge clk_sys);
      check({tag, " ack_low_before"}, 64'(sd_ack), 64'd0);
      sd_lba = lba;
      sd_rd  = rd;
      sd_wr  = wr;
`ifdef SDRESP_WP_EN
      wp = wp_in;
`endif
      stuck_target = n_stuck_done + stuck;
      @(negedge clk_sys);
      check({tag, " ack_one_cycle_later"}, 64'(sd_ack), 64'd1);
      while (sd_ack && cyc < XFER_BUDGET) begin
         @(negedge clk_sys);
         cyc++;
      end
      check({tag, " ack_fell_in_budget"}, 64'(cyc < XFER_BUDGET), 64'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_sys);
         check({tag, " no_restart_while_held"}, 64'(sd_ack), 64'd0);
      end
      sd_rd = 1'b0;
      sd_wr = 1'b0;
      repeat (3) @(negedge clk_sys);
      check({tag, " strobe_count"}, 64'(n_strobes - s0), is_read ? 64'd512 : 64'd0);
      check({tag, " strobe_queue_drained"}, 64'(exp_strobe.size()), 64'd0);
      check({tag, " mem_queue_drained"}, 64'(exp_mem.size()), 64'd0);
      check({tag, " idle_ack_low"}, 64'(sd_ack), 64'd0);
      if (is_read) begin
         check({tag, " mem_rd_completions"}, 64'(n_rd_done - rdd0),
               in_rng ? 64'(512 - stuck) : 64'd0);
         if (!in_rng) check({tag, " mem_rd_never"}, 64'(n_rd_cycles - rdc0), 64'd0);
      end else begin
         check({tag, " mem_wr_completions"}, 64'(n_wr_done - wrd0),
               (in_rng && !wp_in) ? 64'd512 : 64'd0);
         if (!in_rng || wp_in) check({tag, " mem_wr_never"}, 64'(n_wr_cycles - wrc0), 64'd0);
      end
      if (stuck > 0) check({tag, " timeout_cycles"}, 64'(last_stuck_len), 64'(MEM_TIMEOUT));
   endtask

   // Start a read, then pull reset while the DUT holds mem_rd for byte at+1.
   task automatic abort_read(input logic [31:0] lba, input int at);
      int cyc = 0;
      push_expect(1'b1, lba, 1'b0, 0);
      @(negedge clk_sys);
      sd_lba = lba;
      sd_rd  = 1'b1;
      while (!(sd_buff_wr && sd_buff_addr == 9'(at)) && cyc < XFER_BUDGET) begin
         @(negedge clk_sys);
         cyc++;
      end
      check("abort strobe_reached", 64'(cyc < XFER_BUDGET), 64'd1);
      repeat (2) @(negedge clk_sys);
      check("abort mem_rd_in_flight", 64'(mem_rd), 64'd1);
      #1;
      reset_n = 1'b0;
      sd_rd   = 1'b0;
      exp_strobe.delete();
      exp_mem.delete();
      @(negedge clk_sys);
      check_outputs_zero("abort");
      reset_n = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_checks = 0; n_pass = 0;
      n_strobes = 0; n_rd_done = 0; n_wr_done = 0; n_rd_cycles = 0; n_wr_cycles = 0;
      lat = 1; stuck_target = 0; n_stuck_done = 0;
      stuck_len = 0; last_stuck_len = 0; wait_cnt = 0; stuck_pending = 1'b0;
      model_img_size = '0;
      reset_n = 1'b0; mount_strobe = 1'b0; mount_size = '0;
      sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0;
      mem_ready = 1'b0; mem_rdata = '0; sd_buff_din = '0;
`ifdef SDRESP_WP_EN
      wp = 1'b0;
`endif
      for (int a = 0; a < MEM_BYTES; a++) mem_img[a] = 8'($urandom);
      for (int i = 0; i < 512; i++) mem_img[32'h600 + i] = 8'(i);

      repeat (3) @(negedge clk_sys);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      @(negedge clk_sys);

      do_mount(20'h2D000);

      lat = 1;
      xfer("rd_lba3", 1'b1, 1'b0, 32'd3, 1'b0, 0, 0);
      xfer("wr_lba5", 1'b0, 1'b1, 32'd5, 1'b0, 0, 0);
      xfer("rd_back_lba5", 1'b1, 1'b0, 32'd5, 1'b0, 0, 0);
      xfer("rd_oor_360", 1'b1, 1'b0, 32'd360, 1'b0, 0, 0);
      xfer("rd_last_359", 1'b1, 1'b0, 32'd359, 1'b0, 0, 0);
      xfer("wr_oor_10000", 1'b0, 1'b1, 32'h10000, 1'b0, 0, 0);
      xfer("both_high", 1'b1, 1'b1, 32'd7, 1'b0, 0, 0);
      xfer("held_after_done", 1'b1, 1'b0, 32'd8, 1'b0, 0, 20);
      lat = 0;
      xfer("rd_timeout", 1'b1, 1'b0, 32'd9, 1'b0, 1, 0);

      for (int r = 0; r < 4; r++) begin
         logic [31:0] lba;
         bit          rd;
         lat = int'($urandom_range(0, 3));
         rd  = 1'($urandom);
         lba = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 359));
         xfer($sformatf("rand%0d", r), rd, !rd, lba, 1'b0, 0, 0);
      end

`ifdef SDRESP_WP_EN
      lat = 1;
      check("wr_blocked_initial", 64'(wr_blocked), 64'd0);
      xfer("wp_write", 1'b0, 1'b1, 32'd0, 1'b1, 0, 0);
      check("wr_blocked_set", 64'(wr_blocked), 64'd1);
      xfer("wp_read_ok", 1'b1, 1'b0, 32'd0, 1'b1, 0, 0);
      check("wr_blocked_sticky", 64'(wr_blocked), 64'd1);
      wp = 1'b0;
      do_mount(20'h2D000);
      check("wr_blocked_cleared_by_mount", 64'(wr_blocked), 64'd0);
`endif

      lat = 2;
      abort_read(32'd4, 100);
      @(negedge clk_sys);
      check("post_reset_img_size", 64'(img_size), 64'd0);
      do_mount(20'h2D000);
      xfer("after_abort", 1'b1, 1'b0, 32'd3, 1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
